// File: rtl/codon_packer.sv
// Scans a nucleotide stream for an ATG start, then packs each following data
// triplet into a 4-bit codon ID until a stop codon or the 5-codon frame limit.
module codon_packer (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] base_in,
  input  logic       base_valid,
  output logic       base_ready,
  output logic [3:0] codon_out,
  output logic       codon_valid,
  input  logic       codon_ready,
  output logic [2:0] codon_total,
  output logic       frame_done,
  output logic       frame_error
);
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;
  localparam logic [2:0] MAX_CODONS = 3'd5;

  typedef enum logic {SEARCH, FRAME} state_e;

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] hist_q, hist_d;
  logic [1:0] hcnt_q, hcnt_d;
  logic [1:0] b1_q, b1_d, b2_q, b2_d;
  logic [3:0] codon_out_q, codon_out_d;
  logic       codon_valid_q, codon_valid_d;
  logic [2:0] codon_total_q, codon_total_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_error_q, frame_error_d;

  logic base_acc, is_start, is_stop;

  assign base_acc = base_valid & ~codon_valid_q;
  assign is_start = (base_in == BASE_G) && (hcnt_q == 2'd2) &&
                    (hist_q[3:2] == BASE_A) && (hist_q[1:0] == BASE_T);
  // TAA, TAG, TGA with base_in as the third base
  assign is_stop  = (b1_q == BASE_T) &&
                    (((b2_q == BASE_A) && ((base_in == BASE_A) || (base_in == BASE_G))) ||
                     ((b2_q == BASE_G) && (base_in == BASE_A)));

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hist_d        = hist_q;
    hcnt_d        = hcnt_q;
    b1_d          = b1_q;
    b2_d          = b2_q;
    codon_out_d   = codon_out_q;
    codon_valid_d = codon_valid_q;
    codon_total_d = codon_total_q;
    frame_done_d  = 1'b0;
    frame_error_d = frame_error_q;

    if (codon_valid_q && codon_ready) codon_valid_d = 1'b0;

    if (base_acc) begin
      case (state_q)
        SEARCH: begin
          if (is_start) begin
            state_d       = FRAME;
            phase_d       = 2'd0;
            codon_total_d = 3'd0;
            hist_d        = 4'd0;
            hcnt_d        = 2'd0;
          end else begin
            hist_d = {hist_q[1:0], base_in};
            hcnt_d = (hcnt_q == 2'd2) ? 2'd2 : hcnt_q + 2'd1;
          end
        end
        default: begin
          case (phase_q)
            2'd0: begin
              b1_d    = base_in;
              phase_d = 2'd1;
            end
            2'd1: begin
              b2_d    = base_in;
              phase_d = 2'd2;
            end
            default: begin
              phase_d = 2'd0;
              if (!is_stop && (codon_total_q < MAX_CODONS)) begin
                codon_out_d   = {b1_q, b2_q};
                codon_valid_d = 1'b1;
                codon_total_d = codon_total_q + 3'd1;
              end else begin
                // stop codon or overflowing frame both close the frame
                if (!is_stop) frame_error_d = 1'b1;
                frame_done_d = 1'b1;
                state_d      = SEARCH;
                hist_d       = 4'd0;
                hcnt_d       = 2'd0;
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEARCH;
      phase_q       <= 2'd0;
      hist_q        <= 4'd0;
      hcnt_q        <= 2'd0;
      b1_q          <= 2'd0;
      b2_q          <= 2'd0;
      codon_out_q   <= 4'd0;
      codon_valid_q <= 1'b0;
      codon_total_q <= 3'd0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hist_q        <= hist_d;
      hcnt_q        <= hcnt_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      codon_out_q   <= codon_out_d;
      codon_valid_q <= codon_valid_d;
      codon_total_q <= codon_total_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign base_ready  = ~codon_valid_q;
  assign codon_out   = codon_out_q;
  assign codon_valid = codon_valid_q;
  assign codon_total = codon_total_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_codon_packer.sv
// Self-checking bench for codon_packer: directed scenarios plus a randomized
// stream, all scored against a queue-based model of the reading-frame rules.
module tb_codon_packer;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] base_in = 2'b00;
  logic       base_valid = 1'b0;
  logic       base_ready;
  logic [3:0] codon_out;
  logic       codon_valid;
  logic       codon_ready = 1'b0;
  logic [2:0] codon_total;
  logic       frame_done;
  logic       frame_error;

  codon_packer dut (
    .clock(clock), .reset(reset), .base_in(base_in), .base_valid(base_valid),
    .base_ready(base_ready), .codon_out(codon_out), .codon_valid(codon_valid),
    .codon_ready(codon_ready), .codon_total(codon_total), .frame_done(frame_done),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // reference model: stream history as queues, frame result per triplet
  bit         m_frame;
  logic [1:0] m_hist[$];
  logic [1:0] m_trip[$];
  int         m_total;
  bit         m_err, m_cv, m_done;
  logic [3:0] m_co;

  int         done_seen, codons_seen;
  logic [3:0] last_co;
  logic       prev_cv;

  task automatic model_reset();
    m_frame = 0; m_hist.delete(); m_trip.delete();
    m_total = 0; m_err = 0; m_cv = 0; m_done = 0; m_co = 4'd0;
    prev_cv = 1'b0;
  endtask

  task automatic model_base(input logic [1:0] b);
    logic [5:0] t;
    if (!m_frame) begin
      m_hist.push_back(b);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      if (m_hist.size() == 3 && m_hist[0] == 2'b00 && m_hist[1] == 2'b11 && m_hist[2] == 2'b10) begin
        m_frame = 1; m_total = 0; m_hist.delete(); m_trip.delete();
      end
    end else begin
      m_trip.push_back(b);
      if (m_trip.size() == 3) begin
        t = {m_trip[0], m_trip[1], m_trip[2]};
        if (t == 6'b110000 || t == 6'b110010 || t == 6'b111000) begin
          m_done = 1; m_frame = 0;
        end else if (m_total < 5) begin
          m_cv = 1; m_co = {m_trip[0], m_trip[1]}; m_total++;
        end else begin
          m_err = 1; m_done = 1; m_frame = 0;
        end
        m_trip.delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] b, input logic r, output bit acc);
    base_valid = v; base_in = b; codon_ready = r;
    @(posedge clock);
    acc = v && !m_cv;
    m_done = 0;
    if (m_cv && r) m_cv = 0;
    if (acc) model_base(b);
    @(negedge clock);
    checks++;
    if ({frame_done, codon_valid, base_ready, codon_out, codon_total, frame_error} !==
        {m_done, m_cv, !m_cv, m_co, 3'(m_total), m_err}) begin
      failures++;
      $display("FAIL cycle t=%0t got fd=%b cv=%b br=%b co=%h tot=%0d err=%b want fd=%b cv=%b br=%b co=%h tot=%0d err=%b",
               $time, frame_done, codon_valid, base_ready, codon_out, codon_total, frame_error,
               m_done, m_cv, !m_cv, m_co, m_total, m_err);
    end
    if (frame_done === 1'b1) done_seen++;
    if (codon_valid === 1'b1 && !prev_cv) begin codons_seen++; last_co = codon_out; end
    prev_cv = codon_valid;
  endtask

  task automatic send(input logic [1:0] b, input bit rnd);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, b, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      n++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout got no transfer in %0d cycles, want transfer", n);
    end
  endtask

  task automatic send_str(input string s, input bit rnd);
    logic [1:0] b;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "A": b = 2'b00;
        "C": b = 2'b01;
        "G": b = 2'b10;
        default: b = 2'b11;
      endcase
      send(b, rnd);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b1, acc);
  endtask

  task automatic clear_counts();
    done_seen = 0; codons_seen = 0; last_co = 4'd0;
  endtask

  // reset with base and codon transfers offered on the same edge
  task automatic test_reset();
    reset = 1'b1; base_valid = 1'b1; base_in = 2'($urandom); codon_ready = 1'b1;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    checks++;
    if ({frame_done, codon_valid, base_ready, codon_out, codon_total, frame_error} !== {1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got fd=%b cv=%b br=%b co=%h tot=%0d err=%b want 0 0 1 0 0 0",
               frame_done, codon_valid, base_ready, codon_out, codon_total, frame_error);
    end
    reset = 1'b0; base_valid = 1'b0;
  endtask

  task automatic test_basic();
    clear_counts();
    send_str("ATGCGATAA", 0); idle(2);
    checks++;
    if ({codons_seen, done_seen, last_co, codon_total, frame_error} !== {32'd1, 32'd1, 4'b0110, 3'd1, 1'b0}) begin
      failures++;
      $display("FAIL basic got codons=%0d done=%0d co=%h tot=%0d err=%b want 1 1 6 1 0",
               codons_seen, done_seen, last_co, codon_total, frame_error);
    end
  endtask

  task automatic test_overlap();
    clear_counts();
    send_str("AATGGGCTGA", 0); idle(2);
    checks++;
    if ({codons_seen, done_seen, last_co, codon_total} !== {32'd1, 32'd1, 4'b1010, 3'd1}) begin
      failures++;
      $display("FAIL overlap got codons=%0d done=%0d co=%h tot=%0d want 1 1 a 1",
               codons_seen, done_seen, last_co, codon_total);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_str("ATGCCCCCCCCCCCCCCCCCC", 0); idle(2);
    checks++;
    if ({codons_seen, done_seen, last_co, codon_total, frame_error} !== {32'd5, 32'd1, 4'b0101, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL overflow got codons=%0d done=%0d co=%h tot=%0d err=%b want 5 1 5 5 1",
               codons_seen, done_seen, last_co, codon_total, frame_error);
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int bad = 0;
    send_str("ATGGGG", 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b01, 1'b0, acc);
      if ({codon_valid, base_ready, codon_out} !== {1'b1, 1'b0, 4'b1010}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d unstable cycles, want 0", bad);
    end
    step(1'b1, 2'b01, 1'b1, acc);
    checks++;
    if ({codon_valid, base_ready} !== 2'b01) begin
      failures++;
      $display("FAIL backpressure_release got cv=%b br=%b want cv=0 br=1", codon_valid, base_ready);
    end
    send_str("TAA", 0); idle(2);
  endtask

  task automatic test_reset_mid();
    send_str("ATGCCC", 0);
    test_reset();
    send_str("ATGCA", 0);
    test_reset();
    clear_counts();
    send_str("ATGTAG", 0); idle(2);
    checks++;
    if ({codons_seen, done_seen, codon_total, frame_error} !== {32'd0, 32'd1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got codons=%0d done=%0d tot=%0d err=%b want 0 1 0 0",
               codons_seen, done_seen, codon_total, frame_error);
    end
  endtask

  task automatic test_atg_in_frame();
    clear_counts();
    send_str("ATGATGTAA", 0); idle(2);
    checks++;
    if ({codons_seen, done_seen, last_co, codon_total} !== {32'd1, 32'd1, 4'b0011, 3'd1}) begin
      failures++;
      $display("FAIL atg_in_frame got codons=%0d done=%0d co=%h tot=%0d want 1 1 3 1",
               codons_seen, done_seen, last_co, codon_total);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) test_reset();
      else step(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 1)), acc);
    end
    idle(3);
  endtask

  initial begin
    model_reset();
    clear_counts();
    test_reset();
    test_basic();
    test_overlap();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_atg_in_frame();
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
